muldiv_unit: RTL and testbench

Iterative signed multiply/divide unit with architectural HI/LO registers. It sits in the execute stage beside the ALU and replaces single-cycle HI/LO arithmetic with a 32-iteration engine. It accepts `mult`/`div` from the D→E pipeline register and serves `mfhi`/`mflo` reads into the E-stage result mux. It raises a stall request to the hazard unit while a result is still being computed.

---
 rtl/muldiv_unit.sv | 129 ++++++++++++
 tb/tb_muldiv_unit.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative signed multiply/divide engine with architectural HI/LO registers.
// One product or quotient bit per cycle; HI/LO change only on the final iteration.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_e,
  input  logic             mult_e,
  input  logic             div_e,
  input  logic [1:0]       mf_e,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] hl_out,
  output logic             busy,
  output logic             stall_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;

  logic [1:0]         state;
  logic [5:0]         count;
  logic [WIDTH-1:0]   absA, absB, origA;
  logic               signA, signB, divZero;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   rem, quo;

  logic               accept, lastIter, negResult;
  logic [WIDTH-1:0]   absSrcA, absSrcB;
  logic [WIDTH:0]     addSum;
  logic [2*WIDTH-1:0] prodNext;
  logic [WIDTH:0]     shifted, trial;
  logic [WIDTH-1:0]   remNext, quoNext;

  assign accept    = (state == IDLE) && (mult_e || div_e) && !flush_e;
  assign lastIter  = (count == 6'(WIDTH - 1));
  assign negResult = signA ^ signB;
  assign absSrcA   = src_a[WIDTH-1] ? -src_a : src_a;
  assign absSrcB   = src_b[WIDTH-1] ? -src_b : src_b;

  // Shift-add: multiplier bits are consumed from the low half of prod,
  // partial sums accumulate into the high half.
  assign addSum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, absA} : '0);
  assign prodNext = {addSum, prod[WIDTH-1:1]};

  // Restoring division: the 33-bit trial's sign says whether the subtract sticks.
  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, absB};
  assign remNext = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quoNext = {quo[WIDTH-2:0], ~trial[WIDTH]};

  assign hl_out    = mf_e[1] ? (mf_e[0] ? lo : hi) : '0;
  assign stall_req = busy && (mult_e || div_e || mf_e[1]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      busy    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      absA    <= '0;
      absB    <= '0;
      origA   <= '0;
      signA   <= 1'b0;
      signB   <= 1'b0;
      divZero <= 1'b0;
      prod    <= '0;
      rem     <= '0;
      quo     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            absA    <= absSrcA;
            absB    <= absSrcB;
            origA   <= src_a;
            signA   <= src_a[WIDTH-1];
            signB   <= src_b[WIDTH-1];
            divZero <= (src_b == '0);
            prod    <= {{WIDTH{1'b0}}, absSrcB};
            rem     <= '0;
            quo     <= absSrcA;
            count   <= '0;
            busy    <= 1'b1;
            state   <= mult_e ? MUL : DIV;
          end
        end
        MUL: begin
          prod <= prodNext;
          if (lastIter) begin
            {hi, lo} <= negResult ? -prodNext : prodNext;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            count <= count + 6'd1;
          end
        end
        DIV: begin
          rem <= remNext;
          quo <= quoNext;
          if (lastIter) begin
            // Divide by zero still runs all iterations, then reports a fixed result.
            if (divZero) begin
              hi <= origA;
              lo <= '1;
            end else begin
              hi <= signA ? -remNext : remNext;
              lo <= negResult ? -quoNext : quoNext;
            end
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            count <= count + 6'd1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed scenarios plus randomized
// back-to-back ops checked against a plain-arithmetic HI/LO model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_e;
  logic        mult_e;
  logic        div_e;
  logic [1:0]  mf_e;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [31:0] hl_out;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  int compared   = 0;
  int mismatched = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_e   (flush_e),
    .mult_e    (mult_e),
    .div_e     (div_e),
    .mf_e      (mf_e),
    .src_a     (src_a),
    .src_b     (src_b),
    .hl_out    (hl_out),
    .busy      (busy),
    .stall_req (stall_req),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: signed MIPS-style HI/LO results from plain arithmetic.
  task automatic refModel(input bit isMul, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] expHi, output logic [31:0] expLo);
    longint      p;
    logic [63:0] pv;
    int          sa, sb;
    if (isMul) begin
      p  = longint'($signed(a)) * longint'($signed(b));
      pv = p;
      expHi = pv[63:32];
      expLo = pv[31:0];
    end else if (b == 32'h0) begin
      expHi = a;
      expLo = 32'hFFFFFFFF;
    end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
      expHi = 32'h0;
      expLo = 32'h80000000;
    end else begin
      sa = $signed(a);
      sb = $signed(b);
      expLo = sa / sb;
      expHi = sa % sb;
    end
  endtask

  task automatic startOp(input bit isMul, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    mult_e = isMul;
    div_e  = !isMul;
    src_a  = a;
    src_b  = b;
    @(posedge clk);
    #1;
    mult_e = 1'b0;
    div_e  = 1'b0;
  endtask

  task automatic measureBusy(output int n);
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    mf_e  = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    compared++;
    if (hl_out !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_hl_out: got %h expected %h", hl_out, 32'h0); end
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    compared++;
    if (stall_req !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_stall: got %b expected 0", stall_req); end
    compared++;
    if (hi !== 32'h0 || lo !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_hilo: got %h_%h expected 0_0", hi, lo); end
    rst_n = 1'b1;
    mf_e  = 2'b00;
  endtask

  task automatic test_mult;
    int n;
    startOp(1'b1, 32'h00000007, 32'hFFFFFFFD);
    measureBusy(n);
    compared++;
    if (n !== 32) begin mismatched++; $display("[TB] FAIL mult_busy_cycles: got %0d expected 32", n); end
    compared++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB)
      begin mismatched++; $display("[TB] FAIL mult_7x-3: got %h_%h expected FFFFFFFF_FFFFFFEB", hi, lo); end
  endtask

  task automatic test_div;
    int n;
    startOp(1'b0, 32'hFFFFFFF9, 32'h00000002);
    measureBusy(n);
    compared++;
    if (n !== 32) begin mismatched++; $display("[TB] FAIL div_busy_cycles: got %0d expected 32", n); end
    compared++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD)
      begin mismatched++; $display("[TB] FAIL div_-7/2: got %h_%h expected FFFFFFFF_FFFFFFFD", hi, lo); end
    startOp(1'b0, 32'h80000000, 32'hFFFFFFFF);
    measureBusy(n);
    compared++;
    if (hi !== 32'h0 || lo !== 32'h80000000)
      begin mismatched++; $display("[TB] FAIL div_min/-1: got %h_%h expected 00000000_80000000", hi, lo); end
  endtask

  task automatic test_div_zero;
    int n;
    startOp(1'b0, 32'h00000005, 32'h00000000);
    measureBusy(n);
    compared++;
    if (n !== 32) begin mismatched++; $display("[TB] FAIL divzero_busy_cycles: got %0d expected 32", n); end
    compared++;
    if (hi !== 32'h00000005 || lo !== 32'hFFFFFFFF)
      begin mismatched++; $display("[TB] FAIL divzero_5/0: got %h_%h expected 00000005_FFFFFFFF", hi, lo); end
  endtask

  task automatic test_stall_mf;
    int n;
    startOp(1'b1, 32'h00010000, 32'h00010000);
    mf_e = 2'b10;
    n = 0;
    @(negedge clk);
    while (stall_req === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    compared++;
    if (n !== 32) begin mismatched++; $display("[TB] FAIL mf_stall_cycles: got %0d expected 32", n); end
    compared++;
    if (hl_out !== 32'h00000001) begin mismatched++; $display("[TB] FAIL mfhi_after_stall: got %h expected 00000001", hl_out); end
    mf_e = 2'b11;
    #1;
    compared++;
    if (hl_out !== 32'h0 || stall_req !== 1'b0)
      begin mismatched++; $display("[TB] FAIL mflo_idle: got %h stall %b expected 00000000 stall 0", hl_out, stall_req); end
    mf_e = 2'b00;
    #1;
    compared++;
    if (hl_out !== 32'h0) begin mismatched++; $display("[TB] FAIL no_read_zero: got %h expected 00000000", hl_out); end
  endtask

  task automatic test_reset_mid_op;
    startOp(1'b0, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    compared++;
    if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL midop_busy_before_reset: got %b expected 1", busy); end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    compared++;
    if (busy !== 1'b0 || stall_req !== 1'b0)
      begin mismatched++; $display("[TB] FAIL midop_reset_busy: got busy %b stall %b expected 0 0", busy, stall_req); end
    compared++;
    if (hi !== 32'h0 || lo !== 32'h0)
      begin mismatched++; $display("[TB] FAIL midop_reset_hilo: got %h_%h expected 0_0", hi, lo); end
  endtask

  task automatic test_flush;
    int n;
    startOp(1'b1, 32'd3, 32'd5);
    measureBusy(n);
    compared++;
    if (hi !== 32'h0 || lo !== 32'd15) begin mismatched++; $display("[TB] FAIL flush_setup: got %h_%h expected 0_0000000f", hi, lo); end
    flush_e = 1'b1;
    div_e   = 1'b1;
    mult_e  = 1'b1;
    src_a   = 32'd100;
    src_b   = 32'd7;
    @(posedge clk);
    #1;
    flush_e = 1'b0;
    div_e   = 1'b0;
    mult_e  = 1'b0;
    @(negedge clk);
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_no_accept: got busy %b expected 0", busy); end
    repeat (3) @(negedge clk);
    compared++;
    if (hi !== 32'h0 || lo !== 32'd15) begin mismatched++; $display("[TB] FAIL flush_hilo_kept: got %h_%h expected 0_0000000f", hi, lo); end
  endtask

  // Requests are held in E while busy, so each op must start the cycle after the previous one completes.
  task automatic test_back_to_back;
    localparam int N = 20;
    bit          opMul [N+1];
    logic [31:0] opA   [N+1];
    logic [31:0] opB   [N+1];
    logic [31:0] expHi, expLo;
    int          n, stallBad;
    for (int k = 0; k <= N; k++) begin
      opMul[k] = ($urandom_range(0, 1) == 1);
      opA[k]   = $urandom;
      opB[k]   = $urandom;
      if (k % 4 == 1) begin
        opA[k] = 32'($signed($urandom_range(0, 200)) - 100);
        opB[k] = 32'($signed($urandom_range(0, 20)) - 10);
      end
      if (k % 7 == 3) begin opMul[k] = 1'b0; opB[k] = 32'h0; end
      if (k % 7 == 5) begin opMul[k] = 1'b0; opA[k] = 32'h80000000; opB[k] = 32'hFFFFFFFF; end
    end
    @(negedge clk);
    mult_e = opMul[0];
    div_e  = !opMul[0];
    src_a  = opA[0];
    src_b  = opB[0];
    for (int k = 0; k < N; k++) begin
      @(posedge clk);
      #1;
      mult_e = opMul[k+1];
      div_e  = !opMul[k+1];
      src_a  = opA[k+1];
      src_b  = opB[k+1];
      n = 0;
      stallBad = 0;
      @(negedge clk);
      while (busy === 1'b1 && n < 40) begin
        n++;
        if (stall_req !== 1'b1) stallBad++;
        @(negedge clk);
      end
      refModel(opMul[k], opA[k], opB[k], expHi, expLo);
      compared++;
      if (n !== 32 || stallBad !== 0)
        begin mismatched++; $display("[TB] FAIL b2b_timing[%0d]: got %0d busy %0d unstalled expected 32 busy 0 unstalled", k, n, stallBad); end
      compared++;
      if (hi !== expHi || lo !== expLo)
        begin mismatched++; $display("[TB] FAIL b2b_result[%0d] %s %h,%h: got %h_%h expected %h_%h",
                                     k, opMul[k] ? "mult" : "div", opA[k], opB[k], hi, lo, expHi, expLo); end
    end
    mult_e = 1'b0;
    div_e  = 1'b0;
    mf_e   = 2'b11;
    #1;
    compared++;
    if (hl_out !== expLo) begin mismatched++; $display("[TB] FAIL b2b_mflo: got %h expected %h", hl_out, expLo); end
    mf_e = 2'b00;
  endtask

  initial begin
    rst_n   = 1'b0;
    flush_e = 1'b0;
    mult_e  = 1'b0;
    div_e   = 1'b0;
    mf_e    = 2'b00;
    src_a   = 32'h0;
    src_b   = 32'h0;
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_stall_mf();
    test_reset_mid_op();
    test_flush();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
